// File: rtl/rf_write_arbiter.sv
// Write-port arbiter and RAW/WAW scoreboard for the 32-entry register file.
// A round-robin grant between the ALU (A) and LSU (B) feeds a registered rf write stage.
module rf_write_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs1,
    input  logic [AW-1:0] issue_rs2,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_stall,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            prio_q, prio_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic            grant_a, grant_b, issue_fire;

    // Grants are suppressed while reset is held so no handshake can complete.
    assign grant_a = rst_n & a_valid & (~b_valid | ~prio_q);
    assign grant_b = rst_n & b_valid & (~a_valid | prio_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign issue_stall = issue_valid &
                         (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
    assign issue_fire  = issue_valid & ~issue_stall;

    // Set from an accepted issue takes precedence over the commit clear.
    assign busy_d[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
        always_comb begin
            busy_d[gi] = busy_q[gi];
            if (rf_we_q && rf_rd_q == AW'(gi)) busy_d[gi] = 1'b0;
            if (issue_fire && issue_rd == AW'(gi)) busy_d[gi] = 1'b1;
        end
    end

    always_comb begin
        prio_d     = prio_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a) begin
            prio_d     = 1'b1;
            rf_rd_d    = a_rd;
            rf_wdata_d = a_data;
            rf_we_d    = (a_rd != '0);
        end else if (grant_b) begin
            prio_d     = 1'b0;
            rf_rd_d    = b_rd;
            rf_wdata_d = b_data;
            rf_we_d    = (b_rd != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            prio_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            prio_q     <= prio_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, round robin, RAW/WAW stalls, x0, same-edge set/clear.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_stall(issue_stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, then drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    endtask

    task automatic req_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        a_valid = v; a_rd = rd; a_data = d;
    endtask

    task automatic req_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        b_valid = v; b_rd = rd; b_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        issue(0, 0, 0, 0);
        req_a(1, 5'd1, 32'h11);
        req_b(0, 0, 0);
        #1;
        chk("rst_a_ready", a_ready, 0);
        tick(); tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        rst_n = 1'b1;

        // Round robin from reset: A, B, A, B.
        req_b(1, 5'd2, 32'h22); #1;
        chk("rr1_a_ready", a_ready, 1);
        chk("rr1_b_ready", b_ready, 0);
        tick();
        req_a(1, 5'd4, 32'h44); #1;
        chk("rr2_rf_we", rf_we, 1);
        chk("rr2_rf_rd", rf_rd, 1);
        chk("rr2_rf_wdata", rf_wdata, 32'h11);
        chk("rr2_b_ready", b_ready, 1);
        chk("rr2_a_ready", a_ready, 0);
        tick();
        req_b(1, 5'd6, 32'h66); #1;
        chk("rr3_rf_wdata", rf_wdata, 32'h22);
        chk("rr3_a_ready", a_ready, 1);
        tick();
        req_a(0, 0, 0); #1;
        chk("rr4_rf_wdata", rf_wdata, 32'h44);
        chk("rr4_b_ready", b_ready, 1);
        tick();
        req_b(1, 5'd8, 32'h88); #1;
        chk("rr5_rf_wdata", rf_wdata, 32'h66);
        chk("rr5_b_only", b_ready, 1);
        tick();
        req_b(1, 5'd10, 32'hAA); #1;
        chk("rr6_rf_rd", rf_rd, 8);
        chk("rr6_b_again", b_ready, 1);
        chk("rr6_a_ready", a_ready, 0);
        tick();
        req_b(0, 0, 0); #1;
        chk("rr7_rf_wdata", rf_wdata, 32'hAA);
        tick(); #1;
        chk("idle_rf_we", rf_we, 0);
        chk("idle_rf_rd", rf_rd, 10);
        chk("idle_rf_wdata", rf_wdata, 32'hAA);

        // RAW: rd=7 issued, then a consumer of x7 stalls until A's write commits.
        issue(1, 0, 0, 5'd7); #1;
        chk("raw_issue", issue_stall, 0);
        tick();
        issue(1, 5'd7, 0, 0);
        req_a(1, 5'd7, 32'hDEADBEEF); #1;
        chk("raw_stall", issue_stall, 1);
        chk("raw_a_ready", a_ready, 1);
        tick();
        req_a(0, 0, 0); #1;
        chk("raw_rf_we", rf_we, 1);
        chk("raw_rf_rd", rf_rd, 7);
        chk("raw_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("raw_stall_n1", issue_stall, 1);
        tick(); #1;
        chk("raw_release", issue_stall, 0);
        issue(0, 0, 0, 0);

        // x0: issue to rd=0 never marks busy, write to rd=0 is dropped.
        tick();
        issue(1, 0, 0, 0); #1;
        chk("x0_issue", issue_stall, 0);
        tick();
        issue(0, 0, 0, 0);
        req_a(1, 0, 32'h12345678); #1;
        chk("x0_a_ready", a_ready, 1);
        tick();
        req_a(0, 0, 0); #1;
        chk("x0_rf_we", rf_we, 0);

        // Same-edge set/clear on x3: unsolicited write commits while rd=3 issues.
        req_a(1, 5'd3, 32'h33); #1;
        chk("se_a_ready", a_ready, 1);
        tick();
        req_a(0, 0, 0);
        issue(1, 0, 0, 5'd3); #1;
        chk("se_rf_we", rf_we, 1);
        chk("se_rf_rd", rf_rd, 3);
        chk("se_issue", issue_stall, 0);
        tick();
        issue(1, 5'd3, 0, 0); #1;
        chk("se_busy_kept", issue_stall, 1);
        req_a(1, 5'd3, 32'h333);
        tick();
        req_a(0, 0, 0); #1;
        chk("se_commit_we", rf_we, 1);
        tick(); #1;
        chk("se_release", issue_stall, 0);

        // WAW on x9: second writer of x9 holds until B commits.
        issue(1, 0, 0, 5'd9); #1;
        chk("waw_issue", issue_stall, 0);
        tick();
        issue(1, 0, 0, 5'd9); #1;
        chk("waw_stall", issue_stall, 1);
        req_b(1, 5'd9, 32'h99); #1;
        chk("waw_b_ready", b_ready, 1);
        tick();
        req_b(0, 0, 0); #1;
        chk("waw_rf_we", rf_we, 1);
        chk("waw_rf_rd", rf_rd, 9);
        chk("waw_stall_n1", issue_stall, 1);
        tick(); #1;
        chk("waw_release", issue_stall, 0);
        issue(0, 0, 0, 0);

        // Mid-stream reset with x5 busy and an A grant in flight.
        tick();
        issue(1, 0, 0, 5'd5);
        tick();
        issue(1, 5'd5, 0, 0);
        req_a(1, 5'd12, 32'hCAFE); #1;
        chk("mr_busy5", issue_stall, 1);
        chk("mr_a_ready", a_ready, 1);
        rst_n = 1'b0; #1;
        chk("mr_a_ready_rst", a_ready, 0);
        tick(); #1;
        chk("mr_rf_we", rf_we, 0);
        chk("mr_rf_rd", rf_rd, 0);
        chk("mr_rf_wdata", rf_wdata, 0);
        chk("mr_stall", issue_stall, 0);
        rst_n = 1'b1;
        req_b(1, 5'd13, 32'hBEEF); #1;
        chk("mr_prio_a", a_ready, 1);
        chk("mr_stall_post", issue_stall, 0);
        tick();
        req_a(0, 0, 0); req_b(0, 0, 0); issue(0, 0, 0, 0); #1;
        chk("mr_new_wdata", rf_wdata, 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
